// File: rtl/rmii_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rmii_pkg
// Purpose  : Shared types and constants for the RMII receive/transmit path:
//            receive FSM state encoding, preamble/SFD dibit codes and the
//            Ethernet CRC-32 constants (reflected form).
// Revision : 1.0 - initial release
// ============================================================================
package rmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rmii_rx_state_t;

    localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
    localparam logic [1:0]  SFD_DIBIT       = 2'b11;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;

    // Reverse bit order of a 32-bit word (reflected <-> natural CRC form).
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage : rmii_pkg
`default_nettype wire

// File: rtl/eth_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module   : eth_crc32_d8
// Purpose  : Combinational byte-wise Ethernet CRC-32 next-state, reflected
//            (LSB-first) form. Shared by the RMII RX checker and TX FCS gen.
// Ports    : i_crc  [31:0]  current CRC register
//            i_data [7:0]   byte to absorb (bit0 = first bit on wire)
//            o_crc  [31:0]  CRC register after absorbing i_data
// Revision : 1.0 - initial release
// ============================================================================
module eth_crc32_d8
    import rmii_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_comb begin : p_crc
        logic [31:0] w_c;
        w_c = i_crc ^ {24'd0, i_data};
        for (int k = 0; k < 8; k++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY_REFL) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule : eth_crc32_d8
`default_nettype wire

// File: rtl/rmii_rxd.sv
`default_nettype none
// ============================================================================
// Module   : rmii_rxd
// Purpose  : RMII receive path. Registers CRS_DV/RXD, strips preamble/SFD,
//            assembles LSB-first dibits into bytes, checks the Ethernet FCS
//            and reports per-frame status on O_eof.
// Ports    : I_clk50m      RMII 50 MHz reference clock
//            I_rst         asynchronous active-high reset
//            I_crs_dv      carrier-sense / data-valid from PHY
//            I_rxd[1:0]    receive dibit, bit0 earlier on the wire
//            O_data[7:0]   received byte (FCS included), holds last byte
//            O_data_valid  1-clk byte strobe
//            O_sof         first byte of frame (with O_data_valid)
//            O_eof         1-clk end-of-frame pulse, qualifies status below
//            O_crc_ok      FCS residue matched
//            O_err         alignment error or length overflow
//            O_len         bytes delivered incl. FCS, saturating
// Revision : 1.0 - initial release
// ============================================================================
module rmii_rxd
    import rmii_pkg::*;
#(
    parameter int MIN_PREAMBLE_DIBITS = 8,
    parameter int MAX_FRAME_BYTES     = 1522,
    parameter int LEN_W               = 11
) (
    input  logic             I_clk50m,
    input  logic             I_rst,
    input  logic             I_crs_dv,
    input  logic [1:0]       I_rxd,
    output logic [7:0]       O_data,
    output logic             O_data_valid,
    output logic             O_sof,
    output logic             O_eof,
    output logic             O_crc_ok,
    output logic             O_err,
    output logic [LEN_W-1:0] O_len
);

    localparam logic [7:0]       c_PRE_THRESH = 8'(MIN_PREAMBLE_DIBITS - 1);
    localparam logic [LEN_W-1:0] c_MAX_LEN    = LEN_W'(MAX_FRAME_BYTES);

    // Input register (stage 0) and one-clock history (stage 1). The FSM
    // consumes the stage-1 dibit; stage 0 acts as a one-clock lookahead so a
    // single low CRS_DV clk (carrier-loss toggling) still counts as data,
    // while two consecutive lows end the frame without absorbing a dibit.
    logic             r_crs_dv;
    logic [1:0]       r_rxd;
    logic             r_crs_dv_d;
    logic [1:0]       r_rxd_d;

    rmii_rx_state_t   r_state;
    rmii_rx_state_t   w_state_next;

    logic [7:0]       r_pre_cnt;
    logic [1:0]       r_dibit_cnt;
    logic [7:0]       r_sr;
    logic [31:0]      r_crc;
    logic [LEN_W-1:0] r_len_cnt;
    logic             r_ovf;
    logic             r_first;

    logic [7:0]       r_data;
    logic             r_data_valid;
    logic             r_sof;
    logic             r_eof;
    logic             r_crc_ok;
    logic             r_err;
    logic [LEN_W-1:0] r_len;

    logic             w_dv_gap;
    logic             w_term;
    logic [7:0]       w_byte;
    logic [31:0]      w_crc_next;

    assign w_dv_gap = !r_crs_dv_d && !r_crs_dv;
    assign w_term   = (r_state == DATA) && w_dv_gap;
    assign w_byte   = {r_rxd_d, r_sr[7:2]};

    eth_crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_next)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk50m or posedge I_rst) begin
        if (I_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_crs_dv_d) begin
                    w_state_next = (r_rxd_d == PREAMBLE_DIBIT) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!r_crs_dv_d) begin
                    w_state_next = IDLE;
                end else if (r_rxd_d == PREAMBLE_DIBIT) begin
                    w_state_next = PREAMBLE;
                end else if ((r_rxd_d == SFD_DIBIT) && (r_pre_cnt >= c_PRE_THRESH)) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next = DROP;
                end
            end
            DATA: begin
                if (w_dv_gap) begin
                    w_state_next = IDLE;
                end
            end
            DROP: begin
                if (w_dv_gap) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk50m or posedge I_rst) begin
        if (I_rst) begin
            r_crs_dv     <= 1'b0;
            r_rxd        <= 2'b00;
            r_crs_dv_d   <= 1'b0;
            r_rxd_d      <= 2'b00;
            r_pre_cnt    <= 8'd0;
            r_dibit_cnt  <= 2'd0;
            r_sr         <= 8'd0;
            r_crc        <= CRC32_INIT;
            r_len_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_first      <= 1'b0;
            r_data       <= 8'd0;
            r_data_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= '0;
        end else begin
            r_crs_dv     <= I_crs_dv;
            r_rxd        <= I_rxd;
            r_crs_dv_d   <= r_crs_dv;
            r_rxd_d      <= r_rxd;
            r_data_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    // The dibit that moves us into PREAMBLE is the first one.
                    r_pre_cnt   <= 8'd1;
                    r_dibit_cnt <= 2'd0;
                    r_crc       <= CRC32_INIT;
                    r_len_cnt   <= '0;
                    r_ovf       <= 1'b0;
                    r_first     <= 1'b1;
                end
                PREAMBLE: begin
                    if ((r_rxd_d == PREAMBLE_DIBIT) && (r_pre_cnt != 8'hFF)) begin
                        r_pre_cnt <= r_pre_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (w_term) begin
                        r_eof    <= 1'b1;
                        // Register is reflected; residue constant is in
                        // natural bit order.
                        r_crc_ok <= (bit_rev32(r_crc) == CRC32_RESIDUE) &&
                                    (r_len_cnt != '0);
                        r_err    <= (r_dibit_cnt != 2'd0) || r_ovf;
                        r_len    <= r_len_cnt;
                    end else begin
                        r_sr        <= w_byte;
                        r_dibit_cnt <= r_dibit_cnt + 2'd1;
                        if (r_dibit_cnt == 2'd3) begin
                            r_data       <= w_byte;
                            r_data_valid <= 1'b1;
                            r_sof        <= r_first;
                            r_first      <= 1'b0;
                            r_crc        <= w_crc_next;
                            if (r_len_cnt == c_MAX_LEN) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_len_cnt <= r_len_cnt + 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign O_data       = r_data;
    assign O_data_valid = r_data_valid;
    assign O_sof        = r_sof;
    assign O_eof        = r_eof;
    assign O_crc_ok     = r_crc_ok;
    assign O_err        = r_err;
    assign O_len        = r_len;

endmodule : rmii_rxd
`default_nettype wire

// File: tb/tb_rmii_rxd.sv
`default_nettype none
// ============================================================================
// Module   : tb_rmii_rxd
// Purpose  : Directed self-checking bench for rmii_rxd: good/corrupt frames,
//            bad preamble, CRS_DV toggling at end, oversize frame, back-to-back
//            frames and asynchronous reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rmii_rxd;

    logic        I_clk50m = 1'b0;
    logic        I_rst    = 1'b1;
    logic        I_crs_dv = 1'b0;
    logic [1:0]  I_rxd    = 2'b00;
    logic [7:0]  O_data;
    logic        O_data_valid;
    logic        O_sof;
    logic        O_eof;
    logic        O_crc_ok;
    logic        O_err;
    logic [10:0] O_len;

    rmii_rxd #(
        .MIN_PREAMBLE_DIBITS (8),
        .MAX_FRAME_BYTES     (1522),
        .LEN_W               (11)
    ) dut (
        .I_clk50m     (I_clk50m),
        .I_rst        (I_rst),
        .I_crs_dv     (I_crs_dv),
        .I_rxd        (I_rxd),
        .O_data       (O_data),
        .O_data_valid (O_data_valid),
        .O_sof        (O_sof),
        .O_eof        (O_eof),
        .O_crc_ok     (O_crc_ok),
        .O_err        (O_err),
        .O_len        (O_len)
    );

    always #10 I_clk50m = ~I_clk50m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // ---------------- output monitor (samples on falling edge) -------------
    int          mon_strobes = 0;
    int          mon_sofs    = 0;
    int          mon_sof_at  = -1;
    int          mon_eofs    = 0;
    int          mon_eof_ok  = 0;
    int          mon_overlap = 0;
    logic        mon_crc_ok  = 1'b0;
    logic        mon_err     = 1'b0;
    logic [10:0] mon_len     = '0;
    logic [7:0]  rx_mem [0:8191];

    always @(negedge I_clk50m) begin
        if (O_data_valid) begin
            rx_mem[mon_strobes & 8191] = O_data;
            if (O_sof) begin
                mon_sofs++;
                mon_sof_at = mon_strobes;
            end
            mon_strobes++;
        end
        if (O_eof) begin
            mon_eofs++;
            mon_crc_ok = O_crc_ok;
            mon_err    = O_err;
            mon_len    = O_len;
            if (O_crc_ok) mon_eof_ok++;
            if (O_data_valid) mon_overlap++;
        end
    end

    // ---------------- frame construction -------------------------------
    logic [7:0] frm [0:1599];

    task automatic build(input int n, input int corrupt);
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            frm[i] = 8'($urandom);
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        fcs = ~c;
        frm[n-4] = fcs[7:0];
        frm[n-3] = fcs[15:8];
        frm[n-2] = fcs[23:16];
        frm[n-1] = fcs[31:24];
        if (corrupt >= 0) frm[corrupt] = frm[corrupt] ^ 8'h01;
    endtask

    task automatic drive(input logic crs, input logic [1:0] d);
        @(negedge I_clk50m);
        I_crs_dv = crs;
        I_rxd    = d;
    endtask

    task automatic reset_mid();
        @(negedge I_clk50m);
        I_rst    = 1'b1;
        I_crs_dv = 1'b0;
        I_rxd    = 2'b00;
        #1;
        chk("rst_mid_outputs",
            {8'd0, O_data, O_data_valid, O_sof, O_eof, O_crc_ok, O_err, O_len}, 32'd0);
        repeat (2) @(negedge I_clk50m);
        I_rst = 1'b0;
        repeat (8) drive(1'b0, 2'b00);
    endtask

    // bad_pre_at: preamble dibit index before which 2'b10 is inserted (-1 none)
    // tog_bytes : trailing bytes sent with CRS_DV toggling 0/1 per clk
    // extra     : stray dibits appended after the last byte
    // abort_at  : byte index at which reset is asserted (-1 none)
    task automatic send_frame(input int n, input int bad_pre_at, input int tog_bytes,
                              input int extra, input int abort_at, input int ipg);
        logic [7:0] b;
        logic       crs;
        int         di;
        di = 0;
        for (int i = 0; i < 9; i++) begin
            b = (i == 8) ? 8'hD5 : 8'h55;
            for (int k = 0; k < 4; k++) begin
                if (di == bad_pre_at) drive(1'b1, 2'b10);
                drive(1'b1, b[2*k +: 2]);
                di++;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                reset_mid();
                return;
            end
            b = frm[i];
            for (int k = 0; k < 4; k++) begin
                crs = 1'b1;
                if (i >= n - tog_bytes) crs = (k % 2 == 1);
                drive(crs, b[2*k +: 2]);
            end
        end
        for (int e = 0; e < extra; e++) drive(1'b1, 2'b10);
        repeat (ipg) drive(1'b0, 2'b00);
    endtask

    function automatic int byte_mismatches(input int base, input int n);
        int mm;
        mm = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_mem[(base + i) & 8191] !== frm[i]) mm++;
        end
        return mm;
    endfunction

    // ---------------- main sequence ------------------------------------
    int s_str, s_sof, s_eof, s_ok;

    task automatic snap();
        s_str = mon_strobes;
        s_sof = mon_sofs;
        s_eof = mon_eofs;
        s_ok  = mon_eof_ok;
    endtask

    initial begin
        repeat (3) @(negedge I_clk50m);
        chk("reset_outputs",
            {8'd0, O_data, O_data_valid, O_sof, O_eof, O_crc_ok, O_err, O_len}, 32'd0);
        I_rst = 1'b0;
        repeat (4) drive(1'b0, 2'b00);

        // Good 64-byte frame
        build(64, -1);
        snap();
        send_frame(64, -1, 0, 0, -1, 8);
        chk("good_strobes", mon_strobes - s_str, 64);
        chk("good_sof_cnt", mon_sofs - s_sof, 1);
        chk("good_sof_pos", mon_sof_at, s_str);
        chk("good_eof_cnt", mon_eofs - s_eof, 1);
        chk("good_crc_ok", mon_crc_ok, 1);
        chk("good_err", mon_err, 0);
        chk("good_len", mon_len, 64);
        chk("good_bytes", byte_mismatches(s_str, 64), 0);

        // Byte 10 corrupted
        build(64, 10);
        snap();
        send_frame(64, -1, 0, 0, -1, 8);
        chk("bad_fcs_strobes", mon_strobes - s_str, 64);
        chk("bad_fcs_eof_cnt", mon_eofs - s_eof, 1);
        chk("bad_fcs_crc_ok", mon_crc_ok, 0);
        chk("bad_fcs_err", mon_err, 0);
        chk("bad_fcs_len", mon_len, 64);

        // Broken preamble, then a good frame
        build(64, -1);
        snap();
        send_frame(64, 10, 0, 0, -1, 8);
        chk("bad_pre_strobes", mon_strobes - s_str, 0);
        chk("bad_pre_eof_cnt", mon_eofs - s_eof, 0);
        snap();
        send_frame(64, -1, 0, 0, -1, 8);
        chk("after_pre_strobes", mon_strobes - s_str, 64);
        chk("after_pre_crc_ok", mon_crc_ok, 1);

        // CRS_DV toggling over the last 2 bytes
        build(64, -1);
        snap();
        send_frame(64, -1, 2, 0, -1, 8);
        chk("toggle_strobes", mon_strobes - s_str, 64);
        chk("toggle_eof_cnt", mon_eofs - s_eof, 1);
        chk("toggle_crc_ok", mon_crc_ok, 1);
        chk("toggle_err", mon_err, 0);
        chk("toggle_bytes", byte_mismatches(s_str, 64), 0);
        snap();
        send_frame(64, -1, 2, 2, -1, 8);
        chk("align_strobes", mon_strobes - s_str, 64);
        chk("align_eof_cnt", mon_eofs - s_eof, 1);
        chk("align_err", mon_err, 1);

        // Oversize frame
        build(1600, -1);
        snap();
        send_frame(1600, -1, 0, 0, -1, 8);
        chk("long_strobes", mon_strobes - s_str, 1600);
        chk("long_len", mon_len, 1522);
        chk("long_err", mon_err, 1);

        // Back-to-back with 12-byte IPG
        build(64, -1);
        snap();
        send_frame(64, -1, 0, 0, -1, 48);
        send_frame(64, -1, 0, 0, -1, 48);
        chk("b2b_eof_cnt", mon_eofs - s_eof, 2);
        chk("b2b_crc_ok_cnt", mon_eof_ok - s_ok, 2);

        // Reset at byte 20, then a good frame
        build(64, -1);
        snap();
        send_frame(64, -1, 0, 0, 20, 8);
        chk("abort_eof_cnt", mon_eofs - s_eof, 0);
        snap();
        send_frame(64, -1, 0, 0, -1, 8);
        chk("post_rst_eof_cnt", mon_eofs - s_eof, 1);
        chk("post_rst_crc_ok", mon_crc_ok, 1);
        chk("post_rst_len", mon_len, 64);

        chk("eof_with_strobe", mon_overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rmii_rxd
`default_nettype wire
